// File: rtl/gpr_file.sv
// gpr_file: MIPS general-purpose register file, two combinational read ports and
// one write port, with a per-register pending-write scoreboard for RAW detection.
// Register 0 has no storage: it reads as zero, ignores writes and is never counted.
//
// Parameters: N (data width), Nreg (register count, power of two), K (address
// width), PW (pending-write counter width).
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   ra_addr/ra_q/ra_busy     read port A: address, data, outstanding-write flag
//   rb_addr/rb_q/rb_busy     read port B: address, data, outstanding-write flag
//   claim_en/claim_addr      decode claims a destination register
//   claim_ok                 claim accepted (low only when the counter is saturated)
//   wren/wr_addr/wr_data     writeback strobe, address and data
//   err                      sticky: writeback to a register with no pending claim
//
// Build option: define GPR_BYPASS_EN to forward same-cycle writeback data (and the
// decremented busy) onto a read port whose address matches wr_addr.
module gpr_file #(
  parameter int unsigned N    = 32,
  parameter int unsigned Nreg = 32,
  parameter int unsigned K    = $clog2(Nreg),
  parameter int unsigned PW   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] ra_addr,
  output logic [N-1:0] ra_q,
  output logic         ra_busy,
  input  logic [K-1:0] rb_addr,
  output logic [N-1:0] rb_q,
  output logic         rb_busy,
  input  logic         claim_en,
  input  logic [K-1:0] claim_addr,
  output logic         claim_ok,
  input  logic         wren,
  input  logic [K-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  output logic         err
);

  logic [N-1:0]  regs_q [1:Nreg-1];
  logic [PW-1:0] cnt_q  [1:Nreg-1];
  logic [PW-1:0] cnt_d  [1:Nreg-1];
  logic          err_q, err_d;

  logic [N-1:0]  ra_reg, rb_reg;
  logic [PW-1:0] ra_cnt, rb_cnt, ca_cnt, wa_cnt;
  logic          wr_hit, claim_hit, same_addr, claim_take;

  // Address decode; address 0 never matches, so it yields zero data and count.
  always_comb begin
    ra_reg = '0;
    rb_reg = '0;
    ra_cnt = '0;
    rb_cnt = '0;
    ca_cnt = '0;
    wa_cnt = '0;
    for (int unsigned i = 1; i < Nreg; i++) begin
      if (ra_addr == K'(i)) begin
        ra_reg = regs_q[i];
        ra_cnt = cnt_q[i];
      end
      if (rb_addr == K'(i)) begin
        rb_reg = regs_q[i];
        rb_cnt = cnt_q[i];
      end
      if (claim_addr == K'(i)) ca_cnt = cnt_q[i];
      if (wr_addr == K'(i))    wa_cnt = cnt_q[i];
    end
  end

  assign wr_hit    = wren & (wr_addr != '0);
  assign claim_hit = claim_en & (claim_addr != '0);
  assign same_addr = wr_hit & claim_hit & (wr_addr == claim_addr);

  // A saturated counter can still take a claim if the same edge retires a write to it.
  assign claim_ok   = ~claim_hit | (ca_cnt != {PW{1'b1}}) | same_addr;
  assign claim_take = claim_hit & claim_ok;

  always_comb begin
    for (int unsigned i = 1; i < Nreg; i++) begin
      cnt_d[i] = cnt_q[i];
      if (claim_take && (claim_addr == K'(i)) && !(wr_hit && (wr_addr == K'(i)))) begin
        cnt_d[i] = cnt_q[i] + PW'(1);
      end else if (wr_hit && (wr_addr == K'(i)) && !(claim_take && (claim_addr == K'(i)))) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - PW'(1);
      end
    end
  end

  // Unclaimed writeback is flagged, except when a claim to it lands on the same edge.
  assign err_d = err_q | (wr_hit & ~same_addr & (wa_cnt == '0));
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i < Nreg; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 1; i < Nreg; i++) begin
        if (wr_hit && (wr_addr == K'(i))) regs_q[i] <= wr_data;
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

`ifdef GPR_BYPASS_EN
  logic ra_fwd, rb_fwd;

  assign ra_fwd = wr_hit & (wr_addr == ra_addr);
  assign rb_fwd = wr_hit & (wr_addr == rb_addr);

  // Forwarded port sees the count the write is about to retire.
  assign ra_q    = ra_fwd ? wr_data : ra_reg;
  assign rb_q    = rb_fwd ? wr_data : rb_reg;
  assign ra_busy = ra_fwd ? (ra_cnt > PW'(1)) : (ra_cnt != '0);
  assign rb_busy = rb_fwd ? (rb_cnt > PW'(1)) : (rb_cnt != '0);
`else
  assign ra_q    = ra_reg;
  assign rb_q    = rb_reg;
  assign ra_busy = ra_cnt != '0;
  assign rb_busy = rb_cnt != '0;
`endif

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: a register/count model is compared against the
// DUT on every falling edge, and directed steps add hand-computed literal checks.
module tb_gpr_file;

  localparam int NREG = 32;
  localparam int CMAX = 3;  // 2^PW - 1 with PW = 2

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ra_addr = '0, rb_addr = '0, claim_addr = '0, wr_addr = '0;
  logic [31:0] ra_q, rb_q, wr_data = '0;
  logic        ra_busy, rb_busy, claim_ok, err;
  logic        claim_en = 1'b0, wren = 1'b0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model
  logic [31:0] m_reg [NREG];
  int          m_cnt [NREG];
  bit          m_err;

  gpr_file dut (
    .clk        (clk),
    .rst        (rst),
    .ra_addr    (ra_addr),
    .ra_q       (ra_q),
    .ra_busy    (ra_busy),
    .rb_addr    (rb_addr),
    .rb_q       (rb_q),
    .rb_busy    (rb_busy),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .claim_ok   (claim_ok),
    .wren       (wren),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_claim_ok();
    if (!claim_en || claim_addr == 0) return 1'b1;
    if (m_cnt[claim_addr] < CMAX) return 1'b1;
    return wren && (wr_addr == claim_addr);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
`ifdef GPR_BYPASS_EN
    if (wren && wr_addr != 0 && wr_addr == a) return wr_data;
`endif
    return (a == 0) ? 32'h0 : m_reg[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
`ifdef GPR_BYPASS_EN
    if (wren && wr_addr != 0 && wr_addr == a) return m_cnt[a] > 1;
`endif
    return m_cnt[a] != 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i] = '0;
        m_cnt[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      bit do_claim, do_wr;
      do_claim = claim_en && claim_addr != 0 && exp_claim_ok();
      do_wr    = wren && wr_addr != 0;
      if (do_wr) m_reg[wr_addr] = wr_data;
      if (!(do_claim && do_wr && claim_addr == wr_addr)) begin
        if (do_claim) m_cnt[claim_addr] = m_cnt[claim_addr] + 1;
        if (do_wr) begin
          if (m_cnt[wr_addr] > 0) m_cnt[wr_addr] = m_cnt[wr_addr] - 1;
          else m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model ra_q", ra_q, exp_data(ra_addr));
      chk("model rb_q", rb_q, exp_data(rb_addr));
      chk("model ra_busy", 32'(ra_busy), 32'(exp_busy(ra_addr)));
      chk("model rb_busy", 32'(rb_busy), 32'(exp_busy(rb_addr)));
      chk("model claim_ok", 32'(claim_ok), 32'(exp_claim_ok()));
      chk("model err", 32'(err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    look();
    chk("reset ra_q", ra_q, 32'h0);
    chk("reset ra_busy", 32'(ra_busy), 32'h0);
    chk("reset claim_ok", 32'(claim_ok), 32'h1);
    chk("reset err", 32'(err), 32'h0);
    step();

    for (int a = 0; a < NREG; a++) begin
      ra_addr = 5'(a);
      rb_addr = 5'(31 - a);
      step();
    end

    // r0 discards writes and never raises err
    wren = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; ra_addr = 5'd0;
    step();
    wren = 1'b0;
    look();
    chk("r0 read", ra_q, 32'h0);
    chk("r0 err", 32'(err), 32'h0);
    step();

    claim_en = 1'b1; claim_addr = 5'd5; step();
    claim_addr = 5'd6; step();
    claim_en = 1'b0;
    wren = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; step();
    wr_addr = 5'd6; wr_data = 32'hCAFEF00D; step();
    wren = 1'b0; ra_addr = 5'd5; rb_addr = 5'd6;
    look();
    chk("r5 read", ra_q, 32'h12345678);
    chk("r6 read", rb_q, 32'hCAFEF00D);
    chk("r5 busy", 32'(ra_busy), 32'h0);
    step();
    rb_addr = 5'd5;
    look();
    chk("dual r5", rb_q, 32'h12345678);
    step();

    // Same-cycle write/read of r4 with one pending claim
    claim_en = 1'b1; claim_addr = 5'd4; step();
    claim_en = 1'b0;
    wren = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5A5A5A5; ra_addr = 5'd4;
    look();
`ifdef GPR_BYPASS_EN
    chk("r4 same cycle", ra_q, 32'hA5A5A5A5);
    chk("r4 busy same cycle", 32'(ra_busy), 32'h0);
`else
    chk("r4 same cycle", ra_q, 32'h0);
    chk("r4 busy same cycle", 32'(ra_busy), 32'h1);
`endif
    step();
    wren = 1'b0;
    look();
    chk("r4 next cycle", ra_q, 32'hA5A5A5A5);
    chk("r4 busy next", 32'(ra_busy), 32'h0);
    step();

    // Saturate r7
    claim_en = 1'b1; claim_addr = 5'd7; ra_addr = 5'd7;
    repeat (3) step();
    look();
    chk("r7 sat claim_ok", 32'(claim_ok), 32'h0);
    chk("r7 sat busy", 32'(ra_busy), 32'h1);
    step();
    wren = 1'b1; wr_addr = 5'd7; wr_data = 32'h7;
    look();
    chk("r7 sat claim+write ok", 32'(claim_ok), 32'h1);
    step();
    claim_en = 1'b0; wr_data = 32'h77;
    step();
    step();
    wren = 1'b0;
    look();
    chk("r7 busy after two writes", 32'(ra_busy), 32'h1);
    step();
    wren = 1'b1;
    step();
    wren = 1'b0;
    look();
    chk("r7 busy after third", 32'(ra_busy), 32'h0);
    chk("r7 err", 32'(err), 32'h0);
    step();

    // Claim+write r9 on the same edge
    claim_en = 1'b1; claim_addr = 5'd9; step();
    wren = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; step();
    claim_en = 1'b0; wren = 1'b0; ra_addr = 5'd9;
    look();
    chk("r9 busy held", 32'(ra_busy), 32'h1);
    step();
    wren = 1'b1; step();
    wren = 1'b0;
    look();
    chk("r9 busy cleared", 32'(ra_busy), 32'h0);
    step();
    claim_en = 1'b1; wren = 1'b1; step();
    claim_en = 1'b0; wren = 1'b0;
    look();
    chk("r9 cnt0 claim+write err", 32'(err), 32'h0);
    chk("r9 cnt0 claim+write busy", 32'(ra_busy), 32'h0);
    step();

    // Claim and write to different registers
    claim_en = 1'b1; claim_addr = 5'd12; step();
    claim_addr = 5'd11; wren = 1'b1; wr_addr = 5'd12; wr_data = 32'h12; step();
    claim_en = 1'b0; wren = 1'b0; ra_addr = 5'd11; rb_addr = 5'd12;
    look();
    chk("r11 busy", 32'(ra_busy), 32'h1);
    chk("r12 busy", 32'(rb_busy), 32'h0);
    chk("r12 data", rb_q, 32'h12);
    step();

    // Unclaimed write sets sticky err
    wren = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; step();
    wren = 1'b0; ra_addr = 5'd3;
    look();
    chk("err set", 32'(err), 32'h1);
    chk("r3 data", ra_q, 32'h33);
    step();
    wren = 1'b1; wr_addr = 5'd11; wr_data = 32'h11; step();
    wren = 1'b0; claim_en = 1'b1; claim_addr = 5'd2; step();
    claim_en = 1'b0;
    look();
    chk("err sticky", 32'(err), 32'h1);
    step();

    // Asynchronous reset mid-traffic
    claim_en = 1'b1; claim_addr = 5'd2; wren = 1'b1; wr_addr = 5'd5;
    wr_data = 32'hFFFFFFFF; ra_addr = 5'd5; rb_addr = 5'd2;
    #2 rst = 1'b0;
    #1;
    chk("async rst err", 32'(err), 32'h0);
    chk("async rst r5", ra_q, 32'h0);
    chk("async rst r2 busy", 32'(rb_busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1; claim_en = 1'b0; wren = 1'b0;
    look();
    chk("post rst err", 32'(err), 32'h0);
    chk("post rst r5", ra_q, 32'h0);
    chk("post rst r2 busy", 32'(rb_busy), 32'h0);
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
# gpr_file

Parametrised successor to the single-port general-purpose register array: a multi-ported MIPS register file with two read ports and one write port. It adds a per-register pending-write scoreboard so the decode stage can detect RAW hazards. It sits between decode (read and claim) and writeback (write and release) in each core's pipeline. Register 0 is hardwired to zero.

## Interface
Parameters:
- N, 32, data width in bits
- Nreg, 32, number of architectural registers (power of two, ≥2)
- K, $clog2(Nreg), address width
- PW, 2, width of each pending-write counter (max outstanding writes per register = 2^PW−1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- ra_addr  input  K  read port A address
- ra_q  output  N  read port A data
- ra_busy  output  1  register at ra_addr has an outstanding write
- rb_addr  input  K  read port B address
- rb_q  output  N  read port B data
- rb_busy  output  1  register at rb_addr has an outstanding write
- claim_en  input  1  decode issues an instruction writing claim_addr
- claim_addr  input  K  destination being claimed
- claim_ok  output  1  claim is accepted this cycle
- wren  input  1  writeback strobe
- wr_addr  input  K  writeback address
- wr_data  input  N  writeback data
- err  output  1  sticky: write to a register with zero pending count

## Operation
- Storage: Nreg−1 N-bit registers (1..Nreg−1). Register 0 has no storage; reads return 0, writes are discarded, claims are always accepted and never counted.
- Write: on a rising clk with wren=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
- Reads: ra_q = reg[ra_addr] and rb_q = reg[rb_addr], combinational. Both ports are independent and may address the same register.
- Scoreboard: each register 1..Nreg−1 has a PW-bit counter cnt.
  - claim only (claim_en & claim_ok): cnt[claim_addr] +1.
  - write only (wren, wr_addr≠0): cnt[wr_addr] −1 if cnt>0. If cnt=0, cnt is unchanged and err is set.
  - claim and write to the same address in the same cycle: cnt is unchanged. No err is raised even if cnt=0.
  - claim and write to different addresses: both updates apply.
- claim_ok = ~claim_en | claim_addr==0 | cnt[claim_addr]≠2^PW−1, with the saturated case also accepted when the same-cycle write targets claim_addr. A rejected claim leaves cnt unchanged. Decode must stall and retry.
- ra_busy = cnt[ra_addr]≠0, and rb_busy likewise. Both are 0 for address 0.
- err stays set until reset.

## Timing
- Reset (rst=0, asynchronous): all registers 0, all cnt 0, err 0. Outputs are then ra_q=rb_q=0, ra_busy=rb_busy=0, claim_ok=1.
- Reads have zero latency. A write becomes visible on ra_q/rb_q the cycle after its strobe edge (unless bypass is enabled, see Configuration).
- cnt updates at the rising edge. busy reflects the new count from the next cycle.
- Reset asserted mid-operation clears all state immediately, and any in-flight claim or write is lost. Release from reset is synchronous to the next clk edge.

## Configuration
- GPR_BYPASS_EN defined:
  - When wren=1 and wr_addr≠0 matches a read address, that port returns wr_data in the same cycle (write-through).
  - That port's busy is computed as if the count were cnt−1, so it reads 0 when cnt=1.
- GPR_BYPASS_EN undefined: reads and busy reflect registered state only, with one cycle of write-to-read latency.

## Test plan
- Reset, then read all addresses -> every ra_q/rb_q is 0, every busy is 0, err is 0. Write 0xDEADBEEF to r0 -> reads of r0 still return 0.
- Write 0x12345678 to r5, then 0xCAFEF00D to r6 -> the next cycle ra_addr=5, rb_addr=6 give 0x12345678 and 0xCAFEF00D. With ra_addr=rb_addr=5, both ports read 0x12345678.
- Claim r7 three times (PW=2) -> cnt=3 and ra_busy=1 at ra_addr=7. A fourth claim gives claim_ok=0. Three writes to r7 -> busy=0 after the third.
- Claim r9 and write r9 in the same cycle with cnt=1 -> cnt stays 1 and busy stays 1. Repeat with cnt=0 -> err stays 0.
- Write r3 with cnt=0 -> err=1, and err remains 1 across later valid traffic until rst=0.
- With GPR_BYPASS_EN: wren=1, wr_addr=4, wr_data=0xA5A5A5A5, ra_addr=4 -> ra_q=0xA5A5A5A5 in the same cycle, and ra_busy=0 when cnt[4]=1. Without the macro, ra_q shows the old value that cycle and the new value on the next.
